// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dzo_q, dzo_d;

    logic               signed_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_in = ~op[0];
    assign a_mag     = (signed_in && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag     = (signed_in && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};

    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};
    assign div_ge    = ~div_diff[WIDTH];

    assign prod_fix  = neg_q  ? -acc_q : acc_q;
    assign quo_fix   = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    neg_d  = signed_in & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    rneg_d = signed_in & op_a[WIDTH-1];
                    if (op[1] && (op_b == '0)) begin
                        // Divide by zero skips iteration; HI returns the raw dividend.
                        dz_d    = 1'b1;
                        m_d     = op_a;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                        if (op[1]) begin
                            m_d   = b_mag;
                            acc_d = {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            m_d   = a_mag;
                            acc_d = {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end else begin
                    if (hi_we) hi_d = wr_data;
                    if (lo_we) lo_d = wr_data;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    dzo_d  = dz_q;
                    if (dz_q) begin
                        hi_d = m_q;
                        lo_d = {WIDTH{1'b1}};
                    end else if (op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width. It executes MULT, MULTU, DIV and DIVU over multiple cycles with a start/busy/done handshake, and holds results in HI/LO for MFHI/MFLO. It also supports MTHI/MTLO writes and exception flush. It sits beside mips_ALU in the execute stage of mips_core; the core stalls on `busy` before reading HI/LO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; legal values are ≥4.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation; sampled only when idle.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `op_a`  in  WIDTH  rs value (multiplicand / dividend); sampled with `start`.
- `op_b`  in  WIDTH  rt value (multiplier / divisor); sampled with `start`.
- `hi_we`  in  1  MTHI: write `wr_data` to HI.
- `lo_we`  in  1  MTLO: write `wr_data` to LO.
- `wr_data`  in  WIDTH  MTHI/MTLO data.
- `flush`  in  1  abort any in-flight operation.
- `busy`  out  1  operation in flight; HI/LO not valid.
- `done`  out  1  one-cycle pulse; HI/LO updated this cycle.
- `div_zero`  out  1  pulses with `done` when a DIV/DIVU divisor was 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **States:**
  - IDLE: `busy`=0. Accepts `start`, `hi_we` and `lo_we`.
  - RUN: iterating; `busy`=1.
  - FIX: sign correction and HI/LO write; `busy`=1.
- **Accept (IDLE, `start`=1):**
  - Latch `op`.
  - Signed ops: latch |op_a| and |op_b|, plus result signs.
    - Product sign = a[W-1]^b[W-1].
    - Quotient sign = a[W-1]^b[W-1].
    - Remainder sign = a[W-1].
  - Unsigned ops: latch raw operands.
  - Clear the iteration counter, width clog2(WIDTH+1).
  - Go to RUN, except a DIV/DIVU with `op_b`==0, which goes straight to FIX with the div-zero flag set.
- **Multiply (RUN):** radix-2 shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, exactly WIDTH iterations.
- **Divide (RUN):** restoring shift-subtract, one quotient bit per cycle, exactly WIDTH iterations.
- **FIX:**
  - Negate product, quotient or remainder magnitude (two's complement, truncated to width) where its sign is set.
  - Multiply: HI←upper WIDTH, LO←lower WIDTH.
  - Divide: LO←quotient, HI←remainder.
  - Divide by zero: HI←op_a (raw), LO←all ones, for both signed and unsigned.
  - Go to IDLE.
- **Signed overflow:** DIV of most-negative by −1 gives LO=most-negative, HI=0. This is the natural result; no trap.
- **Priority in IDLE:** `flush` > `start` > `hi_we`/`lo_we`.
  - `start` together with `hi_we` or `lo_we`: the write is dropped.
  - `hi_we` and `lo_we` together: both are written.
- **While busy:** `start`, `hi_we` and `lo_we` are ignored; there is no queueing.
- **`flush`:**
  - In RUN or FIX: returns to IDLE at the next edge. HI/LO keep their pre-operation values; no `done`.
  - In IDLE: no effect beyond blocking that cycle's `start`, `hi_we` and `lo_we`.
- **Reset (any time, including mid-operation):** state=IDLE, `hi`=`lo`=0, `busy`=`done`=`div_zero`=0, counter=0.

## Timing
- Accept edge = E0. `busy` goes to 1 after E0.
- **Normal operation:**
  - RUN occupies edges E1..E_WIDTH.
  - FIX writes HI/LO at edge E_(WIDTH+1).
  - `done` is 1 and `busy` is 0 in the cycle following E_(WIDTH+1).
  - Busy cycles = WIDTH+1; for WIDTH=32 that is 33.
- **Divide by zero:** FIX at E1. `done`=`div_zero`=1 and `busy`=0 in the cycle after E1. Busy cycles = 1.
- `done` and `div_zero` are registered, one cycle wide, and both 0 in all other cycles.
- A new `start` is accepted in the `done` cycle; back-to-back operations carry no bubble.
- MTHI/MTLO: `hi`/`lo` update at the edge where `hi_we`/`lo_we` is sampled high in IDLE.
- `hi`/`lo` are registered outputs and change only at FIX edges, MTHI/MTLO edges, or reset.

## Test plan
- **MULTU** 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32 → `busy` high for exactly 33 cycles, then a one-cycle `done`; HI=0xFFFFFFFE, LO=0x00000001.
- **MULT** −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **DIV** −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIV** 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU** 0x80000000 / 0xFFFFFFFF → LO=0, HI=0x80000000.
- **Divide by zero:** DIVU 5 / 0 → `busy` for 1 cycle; `done`=`div_zero`=1; HI=5, LO=0xFFFFFFFF. A following MTLO 0x1234 gives LO=0x1234 one edge later.
- **Flush and ignored inputs:**
  - Preload HI=0xAAAA, LO=0x5555 via MTHI/MTLO, then start MULT 2×3.
  - Assert `hi_we` and a second `start` at cycle 5: both ignored.
  - Assert `flush` at cycle 10 → `busy`=0 next cycle, no `done`, HI=0xAAAA, LO=0x5555.
  - Start again, then drop `rst_b` mid-RUN → `hi`=`lo`=0, `busy`=0 immediately.
- **WIDTH=8 instance:**
  - MULT 0x80 × 0x80 → HI=0x40, LO=0x00 after 9 busy cycles.
  - DIVU 0xFF / 0x10 → LO=0x0F, HI=0x0F.
  - Back-to-back `start` on the `done` cycle is accepted.
